// File: rtl/uart_pkg.sv
// Shared UART constants, receiver state encoding and the bit-vote helper.
// The transmitter and receiver both derive their bit timing from these constants.
package uart_pkg;

    localparam int unsigned UART_CLK_HZ       = 12000000;
    localparam int unsigned UART_BAUD         = 115200;
    localparam int unsigned UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs (UART RX, buttons).
// Both flops reset to INIT so that an idle line reads as idle straight out of reset.
module uart_sync2 #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= INIT;
            q    <= INIT;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 3-sample majority voting and a one-byte valid/ready holding register.
// Frame errors and overruns are reported as single-cycle pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       uart_rx_i,
    output logic [7:0] uart_dat_o,
    output logic       uart_valid_o,
    input  logic       uart_ready_i,
    output logic       uart_frame_err_o,
    output logic       uart_overrun_o,
    output logic       uart_busy_o
);

    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SAMP_A   = CW'(HALF - 1);
    localparam logic [CW-1:0] SAMP_B   = CW'(HALF);
    localparam logic [CW-1:0] SAMP_C   = CW'(HALF + 1);

    logic          rx_s;
    uart_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          samp_a;
    logic          samp_b;
    logic          decide;
    logic          bit_val;
    logic          drain;

    uart_sync2 #(
        .INIT (1'b1)
    ) u_sync (
        .clk (sys_clk_i),
        .rst (sys_rst_i),
        .d   (uart_rx_i),
        .q   (rx_s)
    );

    always_comb begin
        decide  = (cnt == SAMP_C);
        bit_val = maj3(samp_a, samp_b, rx_s);
        drain   = uart_valid_o & uart_ready_i;
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state            <= IDLE;
            cnt              <= '0;
            bit_idx          <= '0;
            shreg            <= '0;
            samp_a           <= 1'b1;
            samp_b           <= 1'b1;
            uart_dat_o       <= '0;
            uart_valid_o     <= 1'b0;
            uart_frame_err_o <= 1'b0;
            uart_overrun_o   <= 1'b0;
            uart_busy_o      <= 1'b0;
        end else begin
            uart_frame_err_o <= 1'b0;
            uart_overrun_o   <= 1'b0;
            if (drain) begin
                uart_valid_o <= 1'b0;
            end

            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            if (cnt == SAMP_A) begin
                samp_a <= rx_s;
            end
            if (cnt == SAMP_B) begin
                samp_b <= rx_s;
            end

            unique case (state)
                IDLE: begin
                    // The detection cycle counts as cycle 0 of the start bit.
                    cnt <= CW'(1);
                    if (!rx_s) begin
                        state       <= START;
                        uart_busy_o <= 1'b1;
                    end
                end
                START: begin
                    if (decide) begin
                        if (bit_val) begin
                            state       <= IDLE;
                            uart_busy_o <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        shreg   <= {bit_val, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (decide) begin
                        if (bit_val) begin
                            // A byte drained in this same cycle frees the slot for the new one.
                            if (!uart_valid_o || uart_ready_i) begin
                                uart_dat_o   <= shreg;
                                uart_valid_o <= 1'b1;
                            end else begin
                                uart_overrun_o <= 1'b1;
                            end
                            state       <= IDLE;
                            uart_busy_o <= 1'b0;
                        end else begin
                            uart_frame_err_o <= 1'b1;
                            state            <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state       <= IDLE;
                        uart_busy_o <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    uart_busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames plus random bytes at 16 and 104 clocks per bit.
// Stimulus pushes the expected bytes; per-instance monitors pop them on each handshake.
module tb_uart_rx;

    localparam int unsigned CPB_A = 16;
    localparam int unsigned CPB_B = 104;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, rdy_a, val_a, fe_a, ov_a, busy_a;
    logic       rx_b, rdy_b, val_b, fe_b, ov_b, busy_b;
    logic [7:0] dat_a, dat_b;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         fall_cyc[2];
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int         fe_cnt_a = 0, ov_cnt_a = 0, rise_cnt_a = 0, rise_cyc_a = 0;
    int         fe_cnt_b = 0, ov_cnt_b = 0, rise_cnt_b = 0, rise_cyc_b = 0;
    int         fe_exp_a = 0, ov_exp_a = 0;
    logic       prev_val_a = 1'b0, prev_val_b = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(
        .CLKS_PER_BIT (CPB_A)
    ) dut_a (
        .sys_clk_i        (clk),
        .sys_rst_i        (rst),
        .uart_rx_i        (rx_a),
        .uart_dat_o       (dat_a),
        .uart_valid_o     (val_a),
        .uart_ready_i     (rdy_a),
        .uart_frame_err_o (fe_a),
        .uart_overrun_o   (ov_a),
        .uart_busy_o      (busy_a)
    );

    uart_rx #(
        .CLKS_PER_BIT (CPB_B)
    ) dut_b (
        .sys_clk_i        (clk),
        .sys_rst_i        (rst),
        .uart_rx_i        (rx_b),
        .uart_dat_o       (dat_b),
        .uart_valid_o     (val_b),
        .uart_ready_i     (rdy_b),
        .uart_frame_err_o (fe_b),
        .uart_overrun_o   (ov_b),
        .uart_busy_o      (busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else rx_b = v;
    endtask

    // Wire order: start bit, data LSB first, stop bit.
    task automatic send_frame(input int sel, input logic [7:0] data, input logic stop_bit,
                              input int bit_cycles);
        logic [9:0] wire_bits;
        wire_bits = {stop_bit, data, 1'b0};
        fall_cyc[sel] = cyc;
        for (int k = 0; k < 10; k++) begin
            set_rx(sel, wire_bits[k]);
            tick(bit_cycles);
        end
        set_rx(sel, 1'b1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (val_a && rdy_a) begin
                if (q_a.size() == 0) check("unexpected_byte_a", {24'd0, dat_a}, 32'hFFFF_FFFF);
                else check("byte_a", {24'd0, dat_a}, {24'd0, q_a.pop_front()});
            end
            if (fe_a) fe_cnt_a++;
            if (ov_a) ov_cnt_a++;
            if (val_a && !prev_val_a) begin
                rise_cnt_a++;
                rise_cyc_a = cyc;
            end
            prev_val_a = val_a;

            if (val_b && rdy_b) begin
                if (q_b.size() == 0) check("unexpected_byte_b", {24'd0, dat_b}, 32'hFFFF_FFFF);
                else check("byte_b", {24'd0, dat_b}, {24'd0, q_b.pop_front()});
            end
            if (fe_b) fe_cnt_b++;
            if (ov_b) ov_cnt_b++;
            if (val_b && !prev_val_b) begin
                rise_cnt_b++;
                rise_cyc_b = cyc;
            end
            prev_val_b = val_b;
        end else begin
            prev_val_a = 1'b0;
            prev_val_b = 1'b0;
        end
    end

    initial begin
        int         lat;
        int         busy_cycles;
        logic [7:0] rb;
        bit         bad;

        rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        check("reset_dat_a", {24'd0, dat_a}, 32'd0);
        check("reset_valid_a", {31'd0, val_a}, 32'd0);
        check("reset_busy_a", {31'd0, busy_a}, 32'd0);
        check("reset_dat_b", {24'd0, dat_b}, 32'd0);
        check("reset_valid_b", {31'd0, val_b}, 32'd0);

        // Case 1: single byte, latency from the falling edge.
        q_a.push_back(8'hA5);
        send_frame(0, 8'hA5, 1'b1, CPB_A);
        tick(4);
        lat = rise_cyc_a - fall_cyc[0];
        check("a5_latency_in_window", {31'd0, (lat >= 154 && lat <= 156)}, 32'd1);
        check("a5_single_valid", rise_cnt_a, 32'd1);
        check("a5_queue_drained", q_a.size(), 32'd0);

        // Case 2: 5-cycle low glitch.
        busy_cycles = 0;
        rx_a = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) rx_a = 1'b1;
            tick(1);
            if (busy_a) busy_cycles++;
        end
        check("glitch_busy_bounded", {31'd0, (busy_cycles >= 1 && busy_cycles <= 11)}, 32'd1);
        check("glitch_back_idle", {31'd0, busy_a}, 32'd0);
        check("glitch_no_valid", rise_cnt_a, 32'd1);

        // Case 3: bad stop bit, line held low, then a good byte.
        fe_exp_a++;
        send_frame(0, 8'h3C, 1'b0, CPB_A);
        rx_a = 1'b0;
        tick(CPB_A + 40);
        rx_a = 1'b1;
        tick(CPB_A);
        check("break_frame_err_count", fe_cnt_a, fe_exp_a);
        q_a.push_back(8'h81);
        send_frame(0, 8'h81, 1'b1, CPB_A);
        tick(4);
        check("break_then_81_drained", q_a.size(), 32'd0);
        check("break_single_err", fe_cnt_a, fe_exp_a);

        // Case 4: overrun with consumer stalled.
        rdy_a = 1'b0;
        q_a.push_back(8'h11);
        send_frame(0, 8'h11, 1'b1, CPB_A);
        send_frame(0, 8'h22, 1'b1, CPB_A);
        tick(4);
        ov_exp_a++;
        check("overrun_count", ov_cnt_a, ov_exp_a);
        check("overrun_keeps_old", {24'd0, dat_a}, 32'h11);
        check("overrun_valid_held", {31'd0, val_a}, 32'd1);
        rdy_a = 1'b1;
        tick(4);
        check("overrun_drain_one", q_a.size(), 32'd0);
        check("overrun_valid_clear", {31'd0, val_a}, 32'd0);

        // Case 5: handshake in the very cycle the next byte loads.
        rdy_a = 1'b0;
        q_a.push_back(8'h44);
        send_frame(0, 8'h44, 1'b1, CPB_A);
        tick(4);
        q_a.push_back(8'h55);
        fork
            send_frame(0, 8'h55, 1'b1, CPB_A);
            begin
                tick(155);
                rdy_a = 1'b1;
                tick(1);
                rdy_a = 1'b0;
            end
        join
        tick(2);
        check("same_cycle_valid", {31'd0, val_a}, 32'd1);
        check("same_cycle_dat", {24'd0, dat_a}, 32'h55);
        check("same_cycle_popped_44", q_a.size(), 32'd1);
        check("same_cycle_no_overrun", ov_cnt_a, ov_exp_a);
        rdy_a = 1'b1;
        tick(4);
        check("same_cycle_drained", q_a.size(), 32'd0);

        // Case 6: reset mid-frame while the line is high in data bit 4.
        fork
            send_frame(0, 8'hF0, 1'b1, CPB_A);
            begin
                tick(5 * CPB_A + CPB_A / 2);
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                check("midreset_dat", {24'd0, dat_a}, 32'd0);
                check("midreset_valid", {31'd0, val_a}, 32'd0);
                check("midreset_busy", {31'd0, busy_a}, 32'd0);
            end
        join
        tick(CPB_A);
        q_a.push_back(8'h0F);
        send_frame(0, 8'h0F, 1'b1, CPB_A);
        tick(4);
        check("after_reset_0f", q_a.size(), 32'd0);

        // Random bytes with occasional framing errors.
        for (int i = 0; i < 16; i++) begin
            rb  = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            if (bad) begin
                fe_exp_a++;
                send_frame(0, rb, 1'b0, CPB_A);
                rx_a = 1'b0;
                tick($urandom_range(0, 40));
                rx_a = 1'b1;
                tick(4 + $urandom_range(0, 10));
            end else begin
                q_a.push_back(rb);
                send_frame(0, rb, 1'b1, CPB_A);
                tick($urandom_range(0, 20));
            end
        end
        tick(2 * CPB_A);
        check("rand_a_drained", q_a.size(), 32'd0);
        check("rand_a_frame_errs", fe_cnt_a, fe_exp_a);
        check("rand_a_overruns", ov_cnt_a, ov_exp_a);

        // Instance at the default 104-cycle rate.
        q_b.push_back(8'hA5);
        send_frame(1, 8'hA5, 1'b1, CPB_B);
        tick(4);
        lat = rise_cyc_b - fall_cyc[1];
        check("b_a5_latency_in_window", {31'd0, (lat >= 990 && lat <= 992)}, 32'd1);
        check("b_a5_drained", q_b.size(), 32'd0);

        rdy_b = 1'b0;
        q_b.push_back(8'h11);
        send_frame(1, 8'h11, 1'b1, 102);
        send_frame(1, 8'h22, 1'b1, 102);
        tick(8);
        check("b_overrun_count", ov_cnt_b, 32'd1);
        check("b_overrun_keeps_old", {24'd0, dat_b}, 32'h11);
        rdy_b = 1'b1;
        tick(4);
        check("b_overrun_drain_one", q_b.size(), 32'd0);

        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            q_b.push_back(rb);
            send_frame(1, rb, 1'b1, $urandom_range(102, 106));
            tick($urandom_range(0, 30));
        end
        tick(2 * CPB_B);
        check("rand_b_drained", q_b.size(), 32'd0);
        check("b_frame_errs", fe_cnt_b, 32'd0);
        check("b_overruns_total", ov_cnt_b, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
